// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// valid/ready handshakes on input and output. Result is the input mod 10^NDIG.
module bin2bcd_seq #(
   parameter int unsigned IN_W = 5,
   parameter int unsigned NDIG = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*NDIG-1:0]     out_bcd,
   output logic                  out_ovf,
   output logic                  busy
);

   localparam int unsigned BW    = 4 * NDIG;
   localparam int unsigned CW    = $clog2(IN_W + 1);
   localparam int unsigned LIMIT = 10 ** NDIG;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q;
   logic [IN_W-1:0] sh_q, sh_nxt;
   logic [BW-1:0]   bcd_q, bcd_adj, bcd_nxt;
   logic [CW-1:0]   cnt_q;
   logic            ovf_pend_q;
   logic            in_ready_q, out_valid_q, busy_q, out_ovf_q;
   logic [BW-1:0]   out_bcd_q;

   // One double-dabble iteration; the top digit's MSB falls off, giving mod 10^NDIG.
   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < NDIG; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
      bcd_nxt = {bcd_adj[BW-2:0], sh_q[IN_W-1]};
      sh_nxt  = sh_q << 1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sh_q        <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         ovf_pend_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_bcd_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid && in_ready_q) begin
                  sh_q       <= in_bin;
                  bcd_q      <= '0;
                  cnt_q      <= CW'(IN_W);
                  ovf_pend_q <= (32'(in_bin) >= LIMIT);
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StShift;
               end
            end
            StShift: begin
               bcd_q <= bcd_nxt;
               sh_q  <= sh_nxt;
               cnt_q <= cnt_q - CW'(1);
               // Visible outputs change only here, so no partial result is ever shown.
               if (cnt_q == CW'(1)) begin
                  out_bcd_q   <= bcd_nxt;
                  out_ovf_q   <= ovf_pend_q;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_bcd   = out_bcd_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results, monitors pop
// and compare on each output handshake. A second instance covers NDIG=1 truncation.
module tb_bin2bcd_seq;

   typedef struct packed {
      logic [7:0] bcd;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b1;
   logic [4:0] in_bin = '0;
   logic       in_ready, out_valid, out_ovf, busy;
   logic [7:0] out_bcd;

   logic       in_valid1 = 1'b0;
   logic [4:0] in_bin1 = '0;
   logic       in_ready1, out_valid1, out_ovf1, busy1;
   logic [3:0] out_bcd1;

   exp_t q[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_err = 0;
   time  acc_t = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.IN_W(5), .NDIG(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
      .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_ovf(out_ovf),
      .busy(busy)
   );

   bin2bcd_seq #(.IN_W(5), .NDIG(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_bin(in_bin1),
      .out_valid(out_valid1), .out_ready(1'b1), .out_bcd(out_bcd1), .out_ovf(out_ovf1),
      .busy(busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got out_bcd %0h, expected none", out_bcd);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("out_bcd", 32'(out_bcd), 32'(e.bcd));
            check("out_ovf", 32'(out_ovf), 32'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid1) begin
         if (q1.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result1: got out_bcd %0h, expected none", out_bcd1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("out_bcd_ndig1", 32'(out_bcd1), 32'(e.bcd));
            check("out_ovf_ndig1", 32'(out_ovf1), 32'(e.ovf));
         end
      end
   end

   task automatic send(input logic [4:0] v, input logic [7:0] eb, input logic eo,
                       input bit track);
      int n = 0;
      exp_t e;
      in_bin   = v;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: in_ready got 0, expected 1 for in_bin %0d", v);
         in_valid = 1'b0;
      end else begin
         e.bcd = eb;
         e.ovf = eo;
         if (track) q.push_back(e);
         @(posedge clk);
         acc_t = $time;
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic send1(input logic [4:0] v, input logic [3:0] eb, input logic eo);
      int n = 0;
      exp_t e;
      in_bin1   = v;
      in_valid1 = 1'b1;
      @(negedge clk);
      while (!in_ready1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready1) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout1: in_ready got 0, expected 1 for in_bin %0d", v);
      end else begin
         e.bcd = {4'h0, eb};
         e.ovf = eo;
         q1.push_back(e);
         @(posedge clk);
      end
      #1 in_valid1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation got stuck, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      time prev;
      int  n;

      // 1: reset state, then in_bin=0 with latency check
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_bcd", 32'(out_bcd), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      @(posedge clk);
      #1 send(5'd0, 8'h00, 1'b0, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check("latency_out_valid", 32'(out_valid), (k == 6) ? 32'd1 : 32'd0);
         check("latency_busy", 32'(busy), (k == 6) ? 32'd0 : 32'd1);
      end
      @(posedge clk);
      #1;

      // 2: in_bin=31 back-to-back, 7-cycle period
      for (int k = 0; k < 3; k++) begin
         prev = acc_t;
         send(5'd31, 8'h31, 1'b0, 1'b1);
         if (k > 0) check("period_31", 32'(acc_t - prev), 32'd70);
      end

      // 3: sweep 0..31 back-to-back
      for (int v = 0; v < 32; v++) begin
         send(5'(v), 8'(((v / 10) << 4) | (v % 10)), 1'b0, 1'b1);
      end
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("sweep_drained", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;

      // 4: result held with out_ready low; stray in_valid pulses ignored
      out_ready = 1'b0;
      send(5'd19, 8'h19, 1'b0, 1'b1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("hold_reached_done", 32'(out_valid), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1 in_valid = k[0];
         in_bin = 5'(k + 3);
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_out_bcd", 32'(out_bcd), 32'h19);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_in_ready", 32'(in_ready), 32'd1);
      check("release_out_valid", 32'(out_valid), 32'd0);
      check("release_out_bcd_kept", 32'(out_bcd), 32'h19);
      @(posedge clk);
      #1;

      // 5: reset mid-conversion aborts, then a fresh conversion
      send(5'd27, 8'h27, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_out_bcd", 32'(out_bcd), 32'd0);
      check("abort_out_ovf", 32'(out_ovf), 32'd0);
      repeat (8) begin
         @(negedge clk);
         check("abort_no_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1 send(5'd5, 8'h05, 1'b0, 1'b1);

      // 6: single-digit instance truncates and flags overflow
      send1(5'd31, 4'h1, 1'b1);
      send1(5'd9, 4'h9, 1'b0);
      send1(5'd10, 4'h0, 1'b1);

      n = 0;
      while ((q.size() != 0 || q1.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("final_queue_empty", 32'(q.size()), 32'd0);
      check("final_queue1_empty", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
